// File: rtl/spi_pkg.sv
// spi_pkg: FSM states, length and bit-index helpers, and size limit shared by the SPI shift engine
package spi_pkg;
    localparam int MAX_CHAR_LIMIT = 128;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_XFER = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    typedef enum logic [1:0] {IDLE = ST_IDLE, XFER = ST_XFER, DONE = ST_DONE} state_t;
    function automatic logic [7:0] len_eff_f(input logic [7:0] len, input logic [7:0] max_char);
        return (len == 8'd0) ? max_char : len;
    endfunction
    function automatic logic [7:0] bit_index_f(input logic [7:0] cnt, input logic [7:0] len_eff, input logic lsb);
        return lsb ? cnt : len_eff - 8'd1 - cnt;
    endfunction
endpackage

// File: rtl/spi_byte_loader.sv
// spi_byte_loader: byte-enable parallel-load mux for the character register
module spi_byte_loader #(
    parameter int MAX_CHAR = 32,
    localparam int NBYTES = MAX_CHAR / 8
) (
    input  logic                load,
    input  logic [NBYTES-1:0]   byte_sel,
    input  logic [MAX_CHAR-1:0] p_in,
    input  logic [MAX_CHAR-1:0] data,
    output logic [MAX_CHAR-1:0] data_ld
);
    for (genvar k = 0; k < NBYTES; k++) begin : g_lane
        assign data_ld[8*k +: 8] = (load && byte_sel[k]) ? p_in[8*k +: 8] : data[8*k +: 8];
    end
endmodule

// File: rtl/spi_shift_engine.sv
// spi_shift_engine: SPI master character shift engine with transfer FSM; SPI_SHIFT_LOOPBACK_EN adds a mosi-to-sample loopback port
module spi_shift_engine
    import spi_pkg::*;
#(
    parameter int MAX_CHAR = 32,
    parameter int LEN_BITS = $clog2(MAX_CHAR),
    localparam int NBYTES = MAX_CHAR / 8
) (
    input  logic                wb_clk,
    input  logic                wb_reset_n,
    input  logic                go,
    input  logic                abort,
    input  logic [LEN_BITS-1:0] len,
    input  logic                lsb,
    input  logic                tx_negedge,
    input  logic                rx_negedge,
    input  logic                pos_edge,
    input  logic                neg_edge,
    input  logic                load,
    input  logic [NBYTES-1:0]   byte_sel,
    input  logic [MAX_CHAR-1:0] p_in,
    output logic [MAX_CHAR-1:0] p_out,
    input  logic                miso,
`ifdef SPI_SHIFT_LOOPBACK_EN
    input  logic                loopback,
`endif
    output logic                mosi,
    output logic                tip,
    output logic                last,
    output logic                done
);
    if (MAX_CHAR % 8 != 0 || MAX_CHAR < 8 || MAX_CHAR > MAX_CHAR_LIMIT) begin : g_bad_cfg
        $error("spi_shift_engine: MAX_CHAR must be a multiple of 8 in 8..%0d", MAX_CHAR_LIMIT);
    end
    state_t state;
    logic [MAX_CHAR-1:0] data, data_ld, data_nx;
    logic [LEN_BITS:0] tx_cnt, rx_cnt, rx_cnt_nx;
    logic [LEN_BITS-1:0] first_idx, tx_idx, rx_idx;
    logic [7:0] len_eff;
    logic tx_stb, rx_stb, tx_fire, rx_fire, rx_bit;
    spi_byte_loader #(.MAX_CHAR(MAX_CHAR)) u_loader (
        .load(load),
        .byte_sel(byte_sel),
        .p_in(p_in),
        .data(data),
        .data_ld(data_ld)
    );
    assign len_eff = len_eff_f(8'(len), 8'(MAX_CHAR));
    assign tx_stb = tx_negedge ? neg_edge : pos_edge;
    assign rx_stb = rx_negedge ? neg_edge : pos_edge;
`ifdef SPI_SHIFT_LOOPBACK_EN
    assign rx_bit = loopback ? mosi : miso;
`else
    assign rx_bit = miso;
`endif
    assign first_idx = LEN_BITS'(bit_index_f(8'd0, len_eff, lsb));
    assign tx_idx = LEN_BITS'(bit_index_f(8'(tx_cnt), len_eff, lsb));
    assign rx_idx = LEN_BITS'(bit_index_f(8'(rx_cnt), len_eff, lsb));
    assign rx_fire = state == XFER && !abort && rx_stb;
    assign rx_cnt_nx = rx_cnt + {{LEN_BITS{1'b0}}, rx_fire};
    // a bit may only be driven once the receiver has caught up, so it is never read after being overwritten
    assign tx_fire = state == XFER && !abort && tx_stb && 8'(tx_cnt) < len_eff && tx_cnt <= rx_cnt_nx;
    always_comb begin
        data_nx = (state == IDLE) ? data_ld : data;
        if (rx_fire)
            data_nx[rx_idx] = rx_bit;
    end
    always_ff @(posedge wb_clk) begin
        if (!wb_reset_n) begin
            state  <= IDLE;
            data   <= '0;
            mosi   <= 1'b0;
            tx_cnt <= '0;
            rx_cnt <= '0;
        end else begin
            data <= data_nx;
            case (state)
                IDLE: if (go) begin
                    state  <= XFER;
                    mosi   <= data_ld[first_idx];
                    tx_cnt <= {{LEN_BITS{1'b0}}, 1'b1};
                    rx_cnt <= '0;
                end
                XFER: if (abort) begin
                    state <= IDLE;
                end else begin
                    rx_cnt <= rx_cnt_nx;
                    if (tx_fire) begin
                        mosi   <= data[tx_idx];
                        tx_cnt <= tx_cnt + {{LEN_BITS{1'b0}}, 1'b1};
                    end
                    if (8'(rx_cnt_nx) == len_eff)
                        state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
    assign tip = state == XFER;
    assign done = state == DONE;
    assign last = tip && 8'(rx_cnt) == len_eff - 8'd1;
    assign p_out = data;
endmodule

// File: tb/tb_spi_shift_engine.sv
// tb_spi_shift_engine: randomized scoreboard bench for spi_shift_engine against a word-level transfer model
`timescale 1ns/1ps
module tb_spi_shift_engine;
    localparam int MC = 32;
    typedef struct {
        logic [31:0] pout;
        logic [31:0] ser;
        int          le;
    } exp_t;
    logic wb_clk = 1'b0, wb_reset_n = 1'b0, go = 1'b0, abort = 1'b0, lsb = 1'b0;
    logic tx_negedge = 1'b0, rx_negedge = 1'b0, pos_edge = 1'b0, neg_edge = 1'b0;
    logic load = 1'b0, miso = 1'b0, inv_miso = 1'b0;
    logic [4:0] len = 5'd0;
    logic [3:0] byte_sel = 4'd0;
    logic [31:0] p_in = 32'd0, p_out, mdl = 32'd0;
    logic mosi, tip, last, done;
`ifdef SPI_SHIFT_LOOPBACK_EN
    logic loopback = 1'b0;
`endif
    exp_t sb[$];
    int n_chk = 0, n_fail = 0, cyc = 0, mk = 0, last_rx = -10;
    logic [31:0] mw = 32'd0;
    logic prev_tip = 1'b0;

    always #5 wb_clk = ~wb_clk;

    spi_shift_engine #(.MAX_CHAR(MC)) dut (
        .wb_clk(wb_clk),
        .wb_reset_n(wb_reset_n),
        .go(go),
        .abort(abort),
        .len(len),
        .lsb(lsb),
        .tx_negedge(tx_negedge),
        .rx_negedge(rx_negedge),
        .pos_edge(pos_edge),
        .neg_edge(neg_edge),
        .load(load),
        .byte_sel(byte_sel),
        .p_in(p_in),
        .p_out(p_out),
        .miso(miso),
`ifdef SPI_SHIFT_LOOPBACK_EN
        .loopback(loopback),
`endif
        .mosi(mosi),
        .tip(tip),
        .last(last),
        .done(done)
    );

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endfunction
    function automatic int le_of(input logic [4:0] l);
        return (l == 5'd0) ? MC : int'(l);
    endfunction
    function automatic int idx_of(input int k, input int le, input logic ls);
        return ls ? k : le - 1 - k;
    endfunction
    // register bits touched by the first n serial positions
    function automatic logic [31:0] mask_first(input int n, input int le, input logic ls);
        logic [63:0] m;
        m = (64'd1 << n) - 64'd1;
        return ls ? m[31:0] : 32'(m << (le - n));
    endfunction
    function automatic logic [31:0] ser_of(input logic [31:0] d, input int le, input logic ls);
        logic [31:0] s;
        s = 32'd0;
        for (int k = 0; k < le; k++) s[k] = d[idx_of(k, le, ls)];
        return s;
    endfunction
    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] v, input logic [3:0] sel);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = v[8*b +: 8];
        return r;
    endfunction

    task automatic tick;
        @(posedge wb_clk);
        #1;
    endtask

    task automatic do_load(input logic [31:0] v, input logic [3:0] sel);
        p_in = v; byte_sel = sel; load = 1'b1;
        tick;
        load = 1'b0;
        mdl = merge(mdl, v, sel);
        chk("idle_load", p_out, mdl);
    endtask

    // stop_at >= 0 aborts (or resets when stop_rst) after that many rx strobes
    task automatic xfer(input logic [31:0] mv, input logic [4:0] l, input logic ls, input logic txn,
                        input logic rxn, input int stop_at, input logic stop_rst, input logic mid_load);
        int le, k, g;
        logic pos, is_rx;
        logic [31:0] part;
        exp_t e;
        le = le_of(l); k = 0; pos = 1'b1;
        len = l; lsb = ls; tx_negedge = txn; rx_negedge = rxn;
        e.le = le;
        e.ser = ser_of(mdl, le, ls);
        e.pout = (mdl & ~mask_first(le, le, ls)) | (mv & mask_first(le, le, ls));
        if (stop_at < 0) sb.push_back(e);
        go = 1'b1;
        tick;
        go = 1'b0; load = 1'b0;
        chk("tip_after_go", 32'(tip), 32'd1);
        chk("first_mosi", 32'(mosi), 32'(e.ser[0]));
        while (k < le) begin
            is_rx = pos ? !rxn : rxn;
            if (is_rx) miso = mv[idx_of(k, le, ls)] ^ inv_miso;
            pos_edge = pos; neg_edge = !pos;
            tick;
            pos_edge = 1'b0; neg_edge = 1'b0;
            pos = !pos;
            if (is_rx) begin
                k++;
                part = (mdl & ~mask_first(k, le, ls)) | (mv & mask_first(k, le, ls));
                if (k == stop_at) begin
                    if (stop_rst) begin
                        wb_reset_n = 1'b0;
                        tick;
                        wb_reset_n = 1'b1;
                        chk("tip_after_reset", 32'(tip), 32'd0);
                        chk("mosi_after_reset", 32'(mosi), 32'd0);
                        chk("p_out_after_reset", p_out, 32'd0);
                        mdl = 32'd0;
                    end else begin
                        abort = 1'b1;
                        tick;
                        abort = 1'b0;
                        chk("tip_after_abort", 32'(tip), 32'd0);
                        chk("p_out_after_abort", p_out, part);
                        mdl = part;
                    end
                    repeat (4) tick;
                    return;
                end
                if (k == 1 && mid_load && le > 1) begin
                    load = 1'b1; go = 1'b1; byte_sel = 4'hF; p_in = $urandom;
                    tick;
                    load = 1'b0; go = 1'b0;
                    chk("load_in_xfer_ignored", p_out, part);
                end
            end
            g = $urandom_range(0, 2);
            repeat (g) tick;
        end
        repeat (3) tick;
        mdl = e.pout;
    endtask

    always @(negedge wb_clk) begin : mon
        exp_t e;
        cyc++;
        if (tip && !prev_tip) begin
            mk = 0; mw = 32'd0;
        end
        if (tip && (rx_negedge ? neg_edge : pos_edge)) begin
            chk("last_flag", 32'(last), 32'(mk == le_of(len) - 1));
            if (mk < 32) mw[mk] = mosi;
            mk++;
            last_rx = cyc;
        end
        if (done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'(done), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("p_out_at_done", p_out, e.pout);
                chk("mosi_stream", mw, e.ser);
                chk("rx_strobes_in_tip", 32'(mk), 32'(e.le));
                chk("done_latency", 32'(cyc - last_rx), 32'd1);
                chk("tip_at_done", 32'(tip), 32'd0);
            end
        end
        prev_tip = tip;
    end

    initial begin
        logic [31:0] d;
        logic [3:0] sel;
        tick; tick;
        chk("reset_tip", 32'(tip), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_mosi", 32'(mosi), 32'd0);
        chk("reset_last", 32'(last), 32'd0);
        chk("reset_p_out", p_out, 32'd0);
        wb_reset_n = 1'b1;
        tick;
        p_in = 32'h11223344; byte_sel = 4'b0101; load = 1'b1;
        tick;
        load = 1'b0;
        chk("byte_lane_load", p_out, 32'h00220044);
        mdl = 32'h00220044;
        do_load(32'h000000A5, 4'hF);
        xfer(32'h0000003C, 5'd8, 1'b0, 1'b1, 1'b0, -1, 1'b0, 1'b1);
        do_load(32'hDEADBEEF, 4'hF);
        xfer($urandom, 5'd0, 1'b1, 1'b0, 1'b1, -1, 1'b0, 1'b1);
        do_load($urandom, 4'hF);
        xfer($urandom, 5'd8, 1'($urandom), 1'($urandom), 1'($urandom), 3, 1'b0, 1'b0);
        do_load($urandom, 4'hF);
        xfer($urandom, 5'd16, 1'($urandom), 1'($urandom), 1'($urandom), 5, 1'b1, 1'b0);
`ifdef SPI_SHIFT_LOOPBACK_EN
        loopback = 1'b1; inv_miso = 1'b1;
        do_load(32'h0000005A, 4'hF);
        xfer(mdl, 5'd8, 1'b0, 1'b1, 1'b0, -1, 1'b0, 1'b0);
        chk("loopback_low_byte", 32'(p_out[7:0]), 32'h5A);
        loopback = 1'b0; inv_miso = 1'b0;
`endif
        for (int t = 0; t < 25; t++) begin
            d = $urandom; sel = 4'($urandom);
            if (t % 2 == 0) begin
                p_in = d; byte_sel = sel; load = 1'b1;
                mdl = merge(mdl, d, sel);
            end else begin
                do_load(d, sel);
            end
            xfer($urandom, 5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), -1, 1'b0, t % 3 == 0);
        end
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
